vector_sweep_capture: RTL

Hardware sweep engine that drives every N_WIDTH-bit input vector into a single-output benchmark DUT and captures each settled response. It sits directly upstream of the DUT, which it stimulates, and directly upstream of the trace logger, to which it emits one (vector, response) record per vector. It also compacts all responses into a MISR signature and a ones-count for golden-model comparison.

---
 rtl/vector_sweep_capture.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vector_sweep_capture.sv
// vector_sweep_capture: walks every N_WIDTH-bit vector into a single-output
// DUT and holds each vector for SETTLE_CYCLES cycles. It then samples the
// response and offers one (vector, response) record to the logger over a
// valid/ready handshake. Responses are also folded into a MISR signature
// and a ones-count.
//
// Record handshake: rec_valid is high only in EMIT. rec_vector and
// rec_response (and dut_in) stay stable while rec_valid=1 and rec_ready=0.
// A record transfers on any rising edge where rec_valid & rec_ready.
// rec_valid is low in the cycle that follows the transfer.
//
// Every output is a register, or a decode of the state register. There is
// no combinational path from rec_ready or dut_out to any output.
module vector_sweep_capture #(
  parameter int                   N_WIDTH       = 5,
  parameter int                   SETTLE_CYCLES = 1,
  parameter int                   SIG_WIDTH     = 16,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY      = 16'h1021
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  output logic [N_WIDTH-1:0]   dut_in,
  input  logic                 dut_out,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_vector,
  output logic                 rec_response,
  output logic                 busy,
  output logic                 done,
  output logic [SIG_WIDTH-1:0] signature,
  output logic [N_WIDTH:0]     ones_count,
  output logic [1:0]           state_o
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_EMIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int                 CW       = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0]      CNT_LOAD = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
  localparam logic [N_WIDTH-1:0] VEC_LAST = {N_WIDTH{1'b1}};
  localparam logic [N_WIDTH-1:0] VEC_ONE  = N_WIDTH'(1);
  localparam logic [N_WIDTH:0]   ONES_MAX = {1'b1, {N_WIDTH{1'b0}}};
  localparam logic [N_WIDTH:0]   ONES_ONE = (N_WIDTH + 1)'(1);

  logic [1:0]           state_q, state_d;
  logic [N_WIDTH-1:0]   vec_q, vec_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [N_WIDTH-1:0]   rec_vector_q, rec_vector_d;
  logic                 rec_response_q, rec_response_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [N_WIDTH:0]     ones_q, ones_d;
  logic [SIG_WIDTH-1:0] misr_next;

  // MISR step: shift left, fold the polynomial in when the MSB falls out, then XOR in the response
  assign misr_next = {sig_q[SIG_WIDTH-2:0], 1'b0}
                   ^ (sig_q[SIG_WIDTH-1] ? SIG_POLY : {SIG_WIDTH{1'b0}})
                   ^ {{(SIG_WIDTH-1){1'b0}}, dut_out};

  // Next-state logic for the sweep FSM, the vector counter, the settle timer and the results
  always_comb begin
    state_d        = state_q;
    vec_d          = vec_q;
    cnt_d          = cnt_q;
    rec_vector_d   = rec_vector_q;
    rec_response_d = rec_response_q;
    sig_d          = sig_q;
    ones_d         = ones_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_SETTLE;
          vec_d   = '0;
          cnt_d   = CNT_LOAD;
          sig_d   = '0;
          ones_d  = '0;
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          // Last settle cycle: the vector has been applied for SETTLE_CYCLES full cycles
          state_d        = S_EMIT;
          rec_vector_d   = vec_q;
          rec_response_d = dut_out;
          sig_d          = misr_next;
          if (dut_out && (ones_q != ONES_MAX)) begin
            ones_d = ones_q + ONES_ONE;
          end
        end
      end
      S_EMIT: begin
        if (rec_ready) begin
          if (vec_q == VEC_LAST) begin
            // The last vector stays on dut_in while DONE
            state_d = S_DONE;
          end else begin
            state_d = S_SETTLE;
            vec_d   = vec_q + VEC_ONE;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset that clears everything, including a partial sweep
  always_ff @(posedge CK) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      vec_q          <= '0;
      cnt_q          <= '0;
      rec_vector_q   <= '0;
      rec_response_q <= 1'b0;
      sig_q          <= '0;
      ones_q         <= '0;
    end else begin
      state_q        <= state_d;
      vec_q          <= vec_d;
      cnt_q          <= cnt_d;
      rec_vector_q   <= rec_vector_d;
      rec_response_q <= rec_response_d;
      sig_q          <= sig_d;
      ones_q         <= ones_d;
    end
  end

  assign dut_in       = vec_q;
  assign rec_valid    = (state_q == S_EMIT);
  assign rec_vector   = rec_vector_q;
  assign rec_response = rec_response_q;
  assign busy         = (state_q == S_SETTLE) || (state_q == S_EMIT);
  assign done         = (state_q == S_DONE);
  assign signature    = sig_q;
  assign ones_count   = ones_q;
  assign state_o      = state_q;

endmodule
